// File: rtl/key_slot_sched_if.sv
// Byte-stream input and chord-slot output bundle of the key-slot scheduler.
interface key_slot_sched_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] key0;
    logic [7:0] key1;
    logic [7:0] key2;
    logic [1:0] state;
    logic       chg;
    logic       drop;

    modport master (
        output in_data, in_valid,
        input  in_ready, key0, key1, key2, state, chg, drop
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, key0, key1, key2, state, chg, drop
    );
endinterface

// File: rtl/key_slot_sched.sv
// Key-slot scheduler: decodes PS/2 make/break sequences and keeps up to
// three held keys ordered newest (key0) to oldest (key2).
//
// state | meaning
// IDLE  | ready for a byte; prefix bytes F0/E0 only set flags
// APPLY | one cycle; the latched make/break is committed to the slots
module key_slot_sched #(
    parameter int MAXK = 3
) (
    input  logic             clk,
    input  logic             clrn,
    key_slot_sched_if.slave  bus
);

    localparam logic [7:0] C_BRK  = 8'hF0;
    localparam logic [7:0] C_EXT  = 8'hE0;
    localparam logic [1:0] C_FULL = 2'(MAXK);

    typedef enum logic {IDLE, APPLY} fsm_t;

    fsm_t       r_fsm;
    fsm_t       w_fsm_nxt;
    logic       r_brk;
    logic       r_ext;
    logic       w_brk_nxt;
    logic       w_ext_nxt;
    logic       w_op_ld;
    logic       r_op_brk;
    logic [7:0] r_op_code;

    logic [7:0] r_key0;
    logic [7:0] r_key1;
    logic [7:0] r_key2;
    logic [1:0] r_cnt;
    logic       r_chg;
    logic       r_drop;

    logic [7:0] w_key0_nxt;
    logic [7:0] w_key1_nxt;
    logic [7:0] w_key2_nxt;
    logic [1:0] w_cnt_nxt;
    logic       w_chg_nxt;
    logic       w_drop_nxt;

    logic       w_take;
    logic       w_hit0;
    logic       w_hit1;
    logic       w_hit2;

    assign w_take = bus.in_valid && (r_fsm == IDLE);

    // Latched code is never 0x00, so an empty slot can never match it.
    assign w_hit0 = (r_key0 == r_op_code);
    assign w_hit1 = (r_key1 == r_op_code);
    assign w_hit2 = (r_key2 == r_op_code);

    // Byte decode: prefixes set flags, anything else clears them and may latch an op.
    always_comb begin
        w_fsm_nxt = r_fsm;
        w_brk_nxt = r_brk;
        w_ext_nxt = r_ext;
        w_op_ld   = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (w_take) begin
                    if (bus.in_data == C_BRK) begin
                        w_brk_nxt = 1'b1;
                    end else if (bus.in_data == C_EXT) begin
                        w_ext_nxt = 1'b1;
                    end else begin
                        w_brk_nxt = 1'b0;
                        w_ext_nxt = 1'b0;
                        if (!r_ext && (bus.in_data != 8'h00)) begin
                            w_op_ld   = 1'b1;
                            w_fsm_nxt = APPLY;
                        end
                    end
                end
            end
            APPLY:   w_fsm_nxt = IDLE;
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // FSM state, prefix flags and the pending operation.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_fsm     <= IDLE;
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
            r_op_brk  <= 1'b0;
            r_op_code <= 8'h00;
        end else begin
            r_fsm <= w_fsm_nxt;
            r_brk <= w_brk_nxt;
            r_ext <= w_ext_nxt;
            if (w_op_ld) begin
                r_op_brk  <= r_brk;
                r_op_code <= bus.in_data;
            end
        end
    end

    // Slot update for the APPLY cycle; all slots and the count move together.
    always_comb begin
        w_key0_nxt = r_key0;
        w_key1_nxt = r_key1;
        w_key2_nxt = r_key2;
        w_cnt_nxt  = r_cnt;
        w_chg_nxt  = 1'b0;
        w_drop_nxt = 1'b0;
        if (r_fsm == APPLY) begin
            if (!r_op_brk) begin
                // A key already held is a typematic repeat and leaves everything alone.
                if (!(w_hit0 || w_hit1 || w_hit2)) begin
                    w_key2_nxt = r_key1;
                    w_key1_nxt = r_key0;
                    w_key0_nxt = r_op_code;
                    w_chg_nxt  = 1'b1;
                    if (r_cnt == C_FULL) begin
                        w_drop_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + 2'd1;
                    end
                end
            end else if (w_hit0) begin
                w_key0_nxt = r_key1;
                w_key1_nxt = r_key2;
                w_key2_nxt = 8'h00;
                w_cnt_nxt  = r_cnt - 2'd1;
                w_chg_nxt  = 1'b1;
            end else if (w_hit1) begin
                w_key1_nxt = r_key2;
                w_key2_nxt = 8'h00;
                w_cnt_nxt  = r_cnt - 2'd1;
                w_chg_nxt  = 1'b1;
            end else if (w_hit2) begin
                w_key2_nxt = 8'h00;
                w_cnt_nxt  = r_cnt - 2'd1;
                w_chg_nxt  = 1'b1;
            end
        end
    end

    // Registered slot outputs and the one-cycle change/drop pulses.
    always_ff @(posedge clk or posedge clrn) begin
        if (clrn) begin
            r_key0 <= 8'h00;
            r_key1 <= 8'h00;
            r_key2 <= 8'h00;
            r_cnt  <= 2'd0;
            r_chg  <= 1'b0;
            r_drop <= 1'b0;
        end else begin
            r_key0 <= w_key0_nxt;
            r_key1 <= w_key1_nxt;
            r_key2 <= w_key2_nxt;
            r_cnt  <= w_cnt_nxt;
            r_chg  <= w_chg_nxt;
            r_drop <= w_drop_nxt;
        end
    end

    assign bus.in_ready = (r_fsm == IDLE);
    assign bus.key0     = r_key0;
    assign bus.key1     = r_key1;
    assign bus.key2     = r_key2;
    assign bus.state    = r_cnt;
    assign bus.chg      = r_chg;
    assign bus.drop     = r_drop;

endmodule

// File: tb/tb_key_slot_sched.sv
// Bench for key_slot_sched: table of bytes with expected slot state after
// each, routed through a scoreboard queue, plus hold and reset corner cases.
module tb_key_slot_sched;

    logic clk;
    logic clrn;

    key_slot_sched_if bus ();

    key_slot_sched #(.MAXK(3)) u_dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic       rdy;
        logic [7:0] k0;
        logic [7:0] k1;
        logic [7:0] k2;
        logic [1:0] st;
        logic       c;
        logic       d;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic [7:0] din, input logic rdy,
                                input logic [7:0] k0, input logic [7:0] k1,
                                input logic [7:0] k2, input logic [1:0] st,
                                input logic c, input logic d);
        vec_t v;
        v.din = din; v.rdy = rdy; v.k0 = k0; v.k1 = k1; v.k2 = k2;
        v.st = st; v.c = c; v.d = d;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Offer a byte until accepted; returns once the accepting edge has passed.
    task automatic drive(input logic [7:0] b, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready) begin
            @(posedge clk);
            ok = 1'b1;
            #1 bus.in_valid = 1'b0;
        end else begin
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t e;
        bit   ok;
        string tag;
        sb.push_back(tbl[idx]);
        drive(tbl[idx].din, ok);
        e = sb.pop_front();
        tag = $sformatf("v%0d", idx);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s_accept: got timeout want accepted", tag);
            return;
        end
        @(negedge clk);
        chk({tag, "_rdy"}, {7'd0, bus.in_ready}, {7'd0, e.rdy});
        @(negedge clk);
        chk({tag, "_k0"}, bus.key0, e.k0);
        chk({tag, "_k1"}, bus.key1, e.k1);
        chk({tag, "_k2"}, bus.key2, e.k2);
        chk({tag, "_st"}, {6'd0, bus.state}, {6'd0, e.st});
        chk({tag, "_chg"}, {7'd0, bus.chg}, {7'd0, e.c});
        chk({tag, "_drop"}, {7'd0, bus.drop}, {7'd0, e.d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int chg_cnt;
        clrn         = 1'b1;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        //          din    rdy  k0     k1     k2     st  chg drop
        tbl.push_back(mk(8'h1C, 1'b0, 8'h1C, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(8'h1B, 1'b0, 8'h1B, 8'h1C, 8'h00, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(8'h23, 1'b0, 8'h23, 8'h1B, 8'h1C, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(8'hF0, 1'b1, 8'h23, 8'h1B, 8'h1C, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(8'h1B, 1'b0, 8'h23, 8'h1C, 8'h00, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(8'h1B, 1'b0, 8'h1B, 8'h23, 8'h1C, 2'd3, 1'b1, 1'b0));
        tbl.push_back(mk(8'h2B, 1'b0, 8'h2B, 8'h1B, 8'h23, 2'd3, 1'b1, 1'b1));
        tbl.push_back(mk(8'h2B, 1'b0, 8'h2B, 8'h1B, 8'h23, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(8'h2B, 1'b0, 8'h2B, 8'h1B, 8'h23, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(8'hF0, 1'b1, 8'h2B, 8'h1B, 8'h23, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(8'h1C, 1'b0, 8'h2B, 8'h1B, 8'h23, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(8'hF0, 1'b1, 8'h2B, 8'h1B, 8'h23, 2'd3, 1'b0, 1'b0));
        tbl.push_back(mk(8'h23, 1'b0, 8'h2B, 8'h1B, 8'h00, 2'd2, 1'b1, 1'b0));
        tbl.push_back(mk(8'hE0, 1'b1, 8'h2B, 8'h1B, 8'h00, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(8'hF0, 1'b1, 8'h2B, 8'h1B, 8'h00, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(8'h75, 1'b1, 8'h2B, 8'h1B, 8'h00, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(8'h00, 1'b1, 8'h2B, 8'h1B, 8'h00, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(8'hF0, 1'b1, 8'h2B, 8'h1B, 8'h00, 2'd2, 1'b0, 1'b0));
        tbl.push_back(mk(8'h2B, 1'b0, 8'h1B, 8'h00, 8'h00, 2'd1, 1'b1, 1'b0));
        tbl.push_back(mk(8'h1B, 1'b0, 8'h1B, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0));
        tbl.push_back(mk(8'hF0, 1'b1, 8'h1B, 8'h00, 8'h00, 2'd1, 1'b0, 1'b0));
        tbl.push_back(mk(8'h1B, 1'b0, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b0));
        tbl.push_back(mk(8'hE0, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0));
        tbl.push_back(mk(8'h1C, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0, 1'b0));

        repeat (2) @(negedge clk);
        clrn = 1'b0;
        @(negedge clk);
        chk("rst_k0", bus.key0, 8'h00);
        chk("rst_k1", bus.key1, 8'h00);
        chk("rst_k2", bus.key2, 8'h00);
        chk("rst_st", {6'd0, bus.state}, 8'h00);
        chk("rst_chg", {7'd0, bus.chg}, 8'h00);
        chk("rst_drop", {7'd0, bus.drop}, 8'h00);
        chk("rst_rdy", {7'd0, bus.in_ready}, 8'h01);

        for (int i = 0; i < tbl.size(); i++) begin
            run_vec(i);
        end

        // in_valid held for three cycles: second acceptance is a repeat, one insertion.
        @(negedge clk);
        bus.in_data  = 8'h1C;
        bus.in_valid = 1'b1;
        chg_cnt = 0;
        @(negedge clk);
        chk("hold_rdy_low", {7'd0, bus.in_ready}, 8'h00);
        if (bus.chg) chg_cnt++;
        @(negedge clk);
        if (bus.chg) chg_cnt++;
        @(negedge clk);
        bus.in_valid = 1'b0;
        if (bus.chg) chg_cnt++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.chg) chg_cnt++;
        end
        chk("hold_chg_cnt", 8'(chg_cnt), 8'd1);
        chk("hold_k0", bus.key0, 8'h1C);
        chk("hold_k1", bus.key1, 8'h00);
        chk("hold_st", {6'd0, bus.state}, 8'h01);

        // Reset during APPLY discards the pending make.
        @(negedge clk);
        bus.in_data  = 8'h1B;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rapply_rdy_low", {7'd0, bus.in_ready}, 8'h00);
        clrn = 1'b1;
        @(negedge clk);
        clrn = 1'b0;
        chg_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.chg) chg_cnt++;
        end
        chk("rapply_chg", 8'(chg_cnt), 8'd0);
        chk("rapply_k0", bus.key0, 8'h00);
        chk("rapply_k1", bus.key1, 8'h00);
        chk("rapply_st", {6'd0, bus.state}, 8'h00);
        chk("rapply_rdy", {7'd0, bus.in_ready}, 8'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
